python_word_aligner_10bit: RTL and testbench
============================================

// Module: python_word_aligner_10bit
// PURPOSE
//  Word-alignment controller directly downstream of the PYTHON 10-bit LVDS receiver.
//  Watches the 10-bit sync-channel word while the sensor sends its training pattern,
//  and pulses the receiver's shared bitslip until the word boundary is correct.
//  Reports lock, failure and per-data-channel training status to the sensor control logic.
// PARAMETERS
//  CHANNELS    4      number of 10-bit data channels beside the sync channel
//  TRAINING    10'h3a6 expected training word on sync and data channels
//  LOCK_COUNT  16     consecutive matching sync words required to declare lock (>=1)
//  SLIP_WAIT   4      idle cycles after each bitslip before re-checking (>=3, ISERDES latency)
//  MAX_SLIP    20     bitslip pulses allowed before declaring failure (>=10)
// PORTS
//  clk          in   1             receiver divided clock (out_clk of receiver)
//  reset_n      in   1             synchronous reset, active low
//  enable       in   1             1: run/hold alignment; 0: return to IDLE, clear status
//  in_data      in   CHANNELS*10   receiver data words, packed [CHANNELS-1:0][9:0]
//  in_sync      in   10            receiver sync-channel word
//  bitslip      out  1             one-cycle bitslip pulse to receiver
//  aligned      out  1             lock achieved
//  error        out  1             MAX_SLIP exhausted without lock
//  slip_count   out  5             bitslip pulses issued since leaving IDLE (saturating at 31)
//  ch_ok        out  CHANNELS      per data channel: in_data[c]==TRAINING when lock was declared
// BEHAVIOUR
//  - All outputs registered. reset_n==0 at a clk edge: state=IDLE; bitslip=0, aligned=0,
//    error=0, slip_count=0, ch_ok=0, internal counters=0. Takes priority over everything.
//  - enable==0 in any state: next state IDLE, same output/counter values as reset (one cycle).
//  - States and transitions (evaluated each clk edge, enable==1):
//    IDLE   : clear counters -> CHECK.
//    CHECK  : in_sync==TRAINING: match_cnt++; when match_cnt reaches LOCK_COUNT-1 on a match
//             -> LOCKED, latch ch_ok[c]=(in_data[c]==TRAINING) the same edge.
//             mismatch: match_cnt=0; slip_count==MAX_SLIP -> FAIL, else -> SLIP.
//    SLIP   : bitslip=1 for exactly this cycle; slip_count++ (saturating); wait_cnt=0 -> WAIT.
//    WAIT   : bitslip=0; wait_cnt++; after SLIP_WAIT cycles in WAIT -> CHECK. in_sync ignored.
//    LOCKED : aligned=1; sticky; no further bitslip; ch_ok held. Leaves only via enable/reset.
//    FAIL   : error=1; sticky; bitslip never asserted. Leaves only via enable/reset.
//  - aligned and error are never both 1. bitslip is never high on consecutive cycles;
//    minimum spacing between pulses is SLIP_WAIT+2 cycles.
//  - Lock latency from first matching word (already aligned): LOCK_COUNT cycles to aligned=1
//    (aligned visible the cycle after the LOCK_COUNT-th match).
//  - A single mismatch during CHECK resets match_cnt; lock needs LOCK_COUNT consecutive matches.
//  - slip_count reflects pulses issued; failure triggers on the first mismatch after
//    slip_count==MAX_SLIP, i.e. exactly MAX_SLIP pulses issued, never MAX_SLIP+1.
//  - enable dropped mid-SLIP: bitslip pulse still completes only if already asserted this cycle;
//    next cycle bitslip=0 and state IDLE.
//  - in_data does not influence state transitions; only sampled into ch_ok on lock.
// TESTING
//  1 Reset: reset_n=0 for 3 clk with enable=1 -> all outputs 0, bitslip never pulses.
//  2 Already aligned: enable=1, in_sync=in_data=3A6 constant -> aligned=1 after 16 matches,
//    slip_count=0, ch_ok=4'b1111, bitslip never asserted.
//  3 Receiver model rotates word by 1 bit per bitslip, initial offset 3 -> exactly 3 pulses,
//    spaced 6 cycles, then aligned=1, slip_count=3; no pulses after lock.
//  4 in_sync stuck at 10'h000 -> 20 pulses then error=1, aligned=0, slip_count=20, no 21st pulse.
//  5 Glitch: aligned stream with one 10'h3a7 at match 10 -> match_cnt restarts, one bitslip
//    issued, lock after realignment; in_data[2]=10'h000 at lock -> ch_ok=4'b1011.
//  6 enable low for 1 cycle while LOCKED / FAIL -> outputs clear, alignment restarts from IDLE.

Source files
------------

// File: rtl/python_word_aligner_10bit.sv
// Word-alignment controller for the PYTHON 10-bit LVDS receiver.
// Slips the shared ISERDES boundary until the sync channel shows the training word.
module python_word_aligner_10bit #(
   parameter int         CHANNELS   = 4,
   parameter logic [9:0] TRAINING   = 10'h3a6,
   parameter int         LOCK_COUNT = 16,
   parameter int         SLIP_WAIT  = 4,
   parameter int         MAX_SLIP   = 20
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     enable,
   input  logic [CHANNELS*10-1:0]   in_data,
   input  logic [9:0]               in_sync,
   output logic                     bitslip,
   output logic                     aligned,
   output logic                     error,
   output logic [4:0]               slip_count,
   output logic [CHANNELS-1:0]      ch_ok
);

   localparam int MW = $clog2(LOCK_COUNT + 1);
   localparam int WW = $clog2(SLIP_WAIT + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CHECK,
      S_SLIP,
      S_WAIT,
      S_LOCKED,
      S_FAIL
   } state_t;

   state_t              state_q, state_d;
   logic [MW-1:0]       match_cnt_q, match_cnt_d;
   logic [WW-1:0]       wait_cnt_q, wait_cnt_d;
   logic [4:0]          slip_count_q, slip_count_d;
   logic [CHANNELS-1:0] ch_ok_q, ch_ok_d;
   logic                bitslip_q, bitslip_d;
   logic                aligned_q, aligned_d;
   logic                error_q, error_d;

   logic                sync_match;
   logic                match_last;
   logic                wait_last;
   logic                slip_max;
   logic [CHANNELS-1:0] data_ok;

   assign sync_match = (in_sync == TRAINING);
   assign match_last = (match_cnt_q == MW'(LOCK_COUNT - 1));
   assign wait_last  = (wait_cnt_q == WW'(SLIP_WAIT - 1));
   assign slip_max   = (slip_count_q == 5'(MAX_SLIP));

   always_comb begin
      data_ok = '0;
      for (int c = 0; c < CHANNELS; c++) begin
         data_ok[c] = (in_data[c*10 +: 10] == TRAINING);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (!enable) begin
         state_d = S_IDLE;
      end else begin
         unique case (state_q)
            S_IDLE:  state_d = S_CHECK;
            S_CHECK: begin
               if (sync_match) begin
                  if (match_last) state_d = S_LOCKED;
               end else if (slip_max) begin
                  state_d = S_FAIL;
               end else begin
                  state_d = S_SLIP;
               end
            end
            S_SLIP:   state_d = S_WAIT;
            S_WAIT:   if (wait_last) state_d = S_CHECK;
            S_LOCKED: state_d = S_LOCKED;
            S_FAIL:   state_d = S_FAIL;
            default:  state_d = S_IDLE;
         endcase
      end
   end

   // Counters advance on the edge that enters a state so flags line up with it.
   always_comb begin
      match_cnt_d  = match_cnt_q;
      wait_cnt_d   = wait_cnt_q;
      slip_count_d = slip_count_q;
      ch_ok_d      = ch_ok_q;
      if (!enable || state_q == S_IDLE) begin
         match_cnt_d  = '0;
         wait_cnt_d   = '0;
         slip_count_d = '0;
         ch_ok_d      = '0;
      end else if (state_q == S_CHECK) begin
         if (sync_match) begin
            match_cnt_d = match_cnt_q + MW'(1);
            if (match_last) ch_ok_d = data_ok;
         end else begin
            match_cnt_d = '0;
         end
      end else if (state_q == S_SLIP) begin
         wait_cnt_d = '0;
      end else if (state_q == S_WAIT) begin
         wait_cnt_d = wait_cnt_q + WW'(1);
      end
      if (state_d == S_SLIP && slip_count_q != 5'd31) begin
         slip_count_d = slip_count_q + 5'd1;
      end
      bitslip_d = (state_d == S_SLIP);
      aligned_d = (state_d == S_LOCKED);
      error_d   = (state_d == S_FAIL);
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         match_cnt_q  <= '0;
         wait_cnt_q   <= '0;
         slip_count_q <= '0;
         ch_ok_q      <= '0;
         bitslip_q    <= 1'b0;
         aligned_q    <= 1'b0;
         error_q      <= 1'b0;
      end else begin
         match_cnt_q  <= match_cnt_d;
         wait_cnt_q   <= wait_cnt_d;
         slip_count_q <= slip_count_d;
         ch_ok_q      <= ch_ok_d;
         bitslip_q    <= bitslip_d;
         aligned_q    <= aligned_d;
         error_q      <= error_d;
      end
   end

   assign bitslip    = bitslip_q;
   assign aligned    = aligned_q;
   assign error      = error_q;
   assign slip_count = slip_count_q;
   assign ch_ok      = ch_ok_q;

endmodule

// File: tb/tb_python_word_aligner_10bit.sv
// Bench for python_word_aligner_10bit: rotating-receiver model with
// event timing predicted from lock/slip arithmetic.
module tb_python_word_aligner_10bit;

   localparam logic [9:0] TRN   = 10'h3a6;
   localparam int         LOCKN = 16;
   localparam int         WAITN = 4;
   localparam int         MAXS  = 20;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        enable = 1'b0;
   logic [39:0] in_data = '0;
   logic [9:0]  in_sync = '0;
   logic        bitslip;
   logic        aligned;
   logic        error;
   logic [4:0]  slip_count;
   logic [3:0]  ch_ok;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   python_word_aligner_10bit dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .enable     (enable),
      .in_data    (in_data),
      .in_sync    (in_sync),
      .bitslip    (bitslip),
      .aligned    (aligned),
      .error      (error),
      .slip_count (slip_count),
      .ch_ok      (ch_ok)
   );

   function automatic logic [9:0] rotl(input logic [9:0] w, input int k);
      logic [9:0] r;
      r = w;
      for (int i = 0; i < k; i++) r = {r[8:0], r[9]};
      return r;
   endfunction

   function automatic logic [9:0] bad_word();
      logic [9:0] w;
      w = 10'($urandom_range(0, 1023));
      if (w == TRN) w = w ^ 10'h001;
      return w;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_clear(input string tag);
      chk(tag, 32'({bitslip, aligned, error, slip_count, ch_ok}), 32'd0);
   endtask

   // Timing model: a CHECK mismatch at edge m re-enters CHECK after
   // WAITN+1 more edges; lock lands LOCKN match edges later.
   task automatic run(input string tag, input int off0, input bit rotate,
                      input int glitch_e, input bit never,
                      input logic [3:0] bad, input bit by_enable);
      int         off;
      int         pulses;
      int         last;
      int         lock_e;
      int         err_e;
      int         exp_pulses;
      int         exp_edge;
      logic [3:0] exp_ok;
      off    = off0;
      pulses = 0;
      last   = -100;
      lock_e = -1;
      err_e  = -1;
      exp_ok = ~bad;
      for (int c = 0; c < 4; c++) begin
         in_data[c*10 +: 10] = bad[c] ? bad_word() : TRN;
      end
      if (never) begin
         exp_pulses = MAXS;
         exp_edge   = 2 + (WAITN + 2) * MAXS;
      end else if (glitch_e > 0) begin
         exp_pulses = 1;
         exp_edge   = glitch_e + WAITN + 1 + LOCKN;
      end else if (off0 == 0) begin
         exp_pulses = 0;
         exp_edge   = 1 + LOCKN;
      end else begin
         exp_pulses = off0;
         exp_edge   = 2 + (WAITN + 2) * (off0 - 1) + WAITN + 1 + LOCKN;
      end
      if (by_enable) begin
         enable  = 1'b0;
         in_sync = 10'h000;
         step();
         chk_clear({tag, "_en_clear"});
         enable = 1'b1;
      end else begin
         reset_n = 1'b0;
         enable  = 1'b1;
         in_sync = 10'h000;
         repeat (3) begin
            step();
            chk_clear({tag, "_reset"});
         end
         reset_n = 1'b1;
      end
      for (int e = 1; e <= exp_edge + 10; e++) begin
         if (never) in_sync = 10'h000;
         else in_sync = rotl(TRN, off) ^ {9'd0, e == glitch_e};
         step();
         if (bitslip) begin
            pulses++;
            if (pulses > 1) chk({tag, "_spacing"}, 32'(e - last), 32'(WAITN + 2));
            last = e;
            if (rotate) off = (off + 9) % 10;
         end
         if (aligned && lock_e < 0) lock_e = e;
         if (error && err_e < 0) err_e = e;
         if (aligned && error) chk({tag, "_both"}, 32'd1, 32'd0);
      end
      chk({tag, "_pulses"}, 32'(pulses), 32'(exp_pulses));
      chk({tag, "_slip_count"}, 32'(slip_count), 32'(exp_pulses));
      if (never) begin
         chk({tag, "_err_edge"}, 32'(err_e), 32'(exp_edge));
         chk({tag, "_aligned"}, 32'(aligned), 32'd0);
         chk({tag, "_error"}, 32'(error), 32'd1);
         chk({tag, "_ch_ok"}, 32'(ch_ok), 32'd0);
      end else begin
         chk({tag, "_lock_edge"}, 32'(lock_e), 32'(exp_edge));
         chk({tag, "_aligned"}, 32'(aligned), 32'd1);
         chk({tag, "_error"}, 32'(error), 32'd0);
         chk({tag, "_ch_ok"}, 32'(ch_ok), 32'(exp_ok));
      end
   endtask

   initial begin
      run("aligned", 0, 1'b1, 0, 1'b0, 4'b0000, 1'b0);
      run("offset3", 3, 1'b1, 0, 1'b0, 4'b0000, 1'b1);
      run("stuck", 0, 1'b0, 0, 1'b1, 4'b0000, 1'b0);
      run("after_fail", 0, 1'b1, 0, 1'b0, 4'b0000, 1'b1);
      run("glitch", 0, 1'b0, 12, 1'b0, 4'b0100, 1'b0);
      for (int i = 0; i < 6; i++) begin
         run("rand", $urandom_range(0, 9), 1'b1, 0, 1'b0,
             4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      end
      for (int i = 0; i < 3; i++) begin
         run("rand_glitch", 0, 1'b0, $urandom_range(2, 1 + LOCKN), 1'b0,
             4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      end
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
